// File: rtl/floo_wormhole_rr_arbiter.sv
// Output-link arbiter for a FlooNoC router port. Round-robin fairness at
// packet granularity with a wormhole lock held from head flit to last flit,
// plus a sticky watchdog that flags packets running past MaxPktLen flits.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no packet owns the link; pick is forwarded straight through
// STALL | head flit offered but not accepted; choice frozen in sel_q
// LOCK  | head accepted; link reserved for sel_q until its last flit
module floo_wormhole_rr_arbiter #(
  parameter int unsigned NumInputs = 5,
  parameter int unsigned FlitWidth = 64,
  parameter int unsigned MaxPktLen = 256,
  localparam int unsigned IdxW = $clog2(NumInputs),
  localparam int unsigned CntW = $clog2(MaxPktLen + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumInputs-1:0]           valid_i,
  output logic [NumInputs-1:0]           ready_o,
  input  logic [NumInputs*FlitWidth-1:0] data_i,
  input  logic [NumInputs-1:0]           last_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [FlitWidth-1:0]           data_o,
  output logic                           last_o,
  output logic [IdxW-1:0]                gnt_idx_o,
  output logic                           locked_o,
  output logic                           timeout_o
);

  typedef enum logic [1:0] {IDLE, STALL, LOCK} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] sel_q, sel_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] flit_cnt_q, flit_cnt_d;
  logic            timeout_q, timeout_d;

  logic [IdxW-1:0] pick;
  logic            pick_vld;
  logic [IdxW-1:0] idx;
  logic [IdxW-1:0] idx_inc;
  logic            hs;

  // Round-robin scan: first valid input starting at rr_ptr_q, wrapping.
  always_comb begin
    pick     = rr_ptr_q;
    pick_vld = 1'b0;
    for (int i = NumInputs - 1; i >= 0; i--) begin
      if (valid_i[(int'(rr_ptr_q) + i) % NumInputs]) begin
        pick     = IdxW'((int'(rr_ptr_q) + i) % NumInputs);
        pick_vld = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Selection, pointer, flit counter and sticky watchdog registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      flit_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      flit_cnt_q <= flit_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state and datapath update; the forwarded index is idx in every state.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    flit_cnt_d = flit_cnt_q;
    hs         = valid_o & ready_i;
    idx_inc    = (idx == IdxW'(NumInputs - 1)) ? '0 : idx + 1'b1;
    unique case (state_q)
      IDLE, STALL: begin
        if (hs) begin
          if (last_o) begin
            state_d    = IDLE;
            rr_ptr_d   = idx_inc;
            flit_cnt_d = '0;
          end else begin
            state_d    = LOCK;
            sel_d      = idx;
            flit_cnt_d = CntW'(1);
          end
        end else if (valid_o) begin
          state_d = STALL;
          sel_d   = idx;
        end
      end
      LOCK: begin
        if (hs) begin
          if (last_o) begin
            state_d    = IDLE;
            rr_ptr_d   = idx_inc;
            flit_cnt_d = '0;
          end else if (flit_cnt_q != CntW'(MaxPktLen)) begin
            flit_cnt_d = flit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Flag in the same edge the counter reaches the limit, then hold.
    timeout_d = timeout_q | ((state_d == LOCK) && (flit_cnt_d == CntW'(MaxPktLen)));
  end

  // Zero-latency forwarding mux and status outputs.
  always_comb begin
    idx       = (state_q == IDLE) ? pick : sel_q;
    valid_o   = valid_i[idx] & ((state_q != IDLE) | pick_vld);
    data_o    = data_i[int'(idx)*FlitWidth +: FlitWidth];
    last_o    = last_i[idx];
    ready_o   = '0;
    if ((state_q != IDLE) || pick_vld) begin
      ready_o[idx] = ready_i;
    end
    gnt_idx_o = idx;
    locked_o  = (state_q != IDLE);
    timeout_o = timeout_q;
  end

`ifndef SYNTHESIS
  a_stall_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == STALL) |-> valid_i[sel_q]);
  a_idx_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    int'(gnt_idx_o) < NumInputs);
  a_ready_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(ready_o));
`endif

endmodule

// File: tb/tb_floo_wormhole_rr_arbiter.sv
// Bench for floo_wormhole_rr_arbiter: per-input flit sources, an expected
// grant-order scoreboard and scenario tasks with inline checks.
module tb_floo_wormhole_rr_arbiter;
  localparam int NI  = 5;
  localparam int FW  = 16;
  localparam int MPL = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NI-1:0]     valid_i = '0;
  logic [NI-1:0]     ready_o;
  logic [NI*FW-1:0]  data_i = '0;
  logic [NI-1:0]     last_i = '0;
  logic              valid_o;
  logic              ready_i = 1'b0;
  logic [FW-1:0]     data_o;
  logic              last_o;
  logic [2:0]        gnt_idx_o;
  logic              locked_o;
  logic              timeout_o;

  typedef struct packed { logic [FW-1:0] data; logic last; } flit_t;
  typedef struct packed { logic [2:0] idx; logic [FW-1:0] data; logic last; } exp_t;

  flit_t         src_q [NI][$];
  exp_t          exp_q [$];
  exp_t          exp_cur;
  logic [NI-1:0] hold = '0;
  logic [NI-1:0] in_hs = '0;
  int            total = 0;
  int            bad = 0;
  int            seq = 0;

  floo_wormhole_rr_arbiter #(
    .NumInputs(NI), .FlitWidth(FW), .MaxPktLen(MPL)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .last_i(last_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .last_o(last_o), .gnt_idx_o(gnt_idx_o),
    .locked_o(locked_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Output monitor: every output handshake pops and checks the scoreboard.
  always @(negedge clk_i) begin
    in_hs = rst_ni ? (valid_i & ready_o) : '0;
    if (rst_ni && valid_o && ready_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got idx=%0d data=%h last=%0d, required no flit",
                 gnt_idx_o, data_o, last_o);
      end else begin
        exp_cur = exp_q.pop_front();
        if ({gnt_idx_o, data_o, last_o} !== exp_cur) begin
          bad++;
          $display("FAIL sb_flit: got idx=%0d data=%h last=%0d, required idx=%0d data=%h last=%0d",
                   gnt_idx_o, data_o, last_o, exp_cur.idx, exp_cur.data, exp_cur.last);
        end
      end
    end
  end

  // Source driver: retire accepted flits, present the next one unless held.
  always @(posedge clk_i) begin
    #2;
    for (int k = 0; k < NI; k++) begin
      if (in_hs[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
      if (src_q[k].size() != 0 && !hold[k]) begin
        valid_i[k]           = 1'b1;
        data_i[k*FW +: FW]   = src_q[k][0].data;
        last_i[k]            = src_q[k][0].last;
      end else begin
        valid_i[k]           = 1'b0;
        data_i[k*FW +: FW]   = '0;
        last_i[k]            = 1'b0;
      end
    end
  end

  task automatic push_pkt(input int k, input int len, input bit has_last,
                          output logic [FW-1:0] first);
    flit_t f;
    first = '0;
    for (int j = 0; j < len; j++) begin
      f.data = FW'((k << 12) | (seq & 12'hfff));
      f.last = has_last && (j == len - 1);
      seq++;
      if (j == 0) first = f.data;
      src_q[k].push_back(f);
      exp_q.push_back({3'(k), f.data, f.last});
    end
  endtask

  task automatic drain(input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < 60) begin
      @(negedge clk_i);
      c++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d flits pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", valid_o); end
    total++; if (ready_o !== '0) begin bad++; $display("FAIL rst_ready: got %b required 0", ready_o); end
    total++; if (locked_o !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b required 0", locked_o); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b required 0", timeout_o); end
  endtask

  task automatic test_rr_single();
    logic [FW-1:0] d;
    @(posedge clk_i); #1;
    for (int k = 0; k < NI; k++) push_pkt(k, 1, 1'b1, d);
    ready_i = 1'b1;
    for (int c = 0; c < NI; c++) begin
      @(negedge clk_i);
      total++;
      if (!(valid_o && gnt_idx_o === 3'(c))) begin
        bad++; $display("FAIL rr_order: cycle %0d got valid=%b idx=%0d, required valid=1 idx=%0d", c, valid_o, gnt_idx_o, c);
      end
      total++; if (locked_o !== 1'b0) begin bad++; $display("FAIL rr_locked: got %b required 0", locked_o); end
    end
    drain("rr_single");
  endtask

  task automatic test_lock();
    logic [FW-1:0] d;
    push_pkt(1, 1, 1'b1, d);
    drain("lock_warmup");
    push_pkt(2, 4, 1'b1, d);
    push_pkt(1, 1, 1'b1, d);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      total++;
      if (!(valid_o && gnt_idx_o === ((c < 4) ? 3'd2 : 3'd1))) begin
        bad++; $display("FAIL lock_grant: cycle %0d got valid=%b idx=%0d, required idx=%0d", c, valid_o, gnt_idx_o, (c < 4) ? 2 : 1);
      end
      if (c < 4) begin
        total++; if (ready_o[1] !== 1'b0) begin bad++; $display("FAIL lock_block: cycle %0d got ready_o[1]=%b required 0", c, ready_o[1]); end
      end
      if (c >= 1 && c <= 3) begin
        total++; if (locked_o !== 1'b1) begin bad++; $display("FAIL lock_locked: cycle %0d got %b required 1", c, locked_o); end
      end
    end
    drain("lock");
  endtask

  task automatic test_stall();
    logic [FW-1:0] d0, d4;
    ready_i = 1'b0;
    push_pkt(0, 1, 1'b1, d0);
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin
        @(posedge clk_i); #1;
        push_pkt(4, 1, 1'b1, d4);
      end
      @(negedge clk_i);
      total++;
      if (!(valid_o && gnt_idx_o === 3'd0 && data_o === d0)) begin
        bad++; $display("FAIL stall_hold: cycle %0d got valid=%b idx=%0d data=%h, required valid=1 idx=0 data=%h", c, valid_o, gnt_idx_o, data_o, d0);
      end
      if (c >= 1) begin
        total++; if (locked_o !== 1'b1) begin bad++; $display("FAIL stall_locked: cycle %0d got %b required 1", c, locked_o); end
      end
    end
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    drain("stall");
  endtask

  task automatic test_bubble();
    logic [FW-1:0] d;
    push_pkt(0, 1, 1'b1, d);
    drain("bubble_warmup");
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin @(posedge clk_i); #1; end
      if (c == 0) begin push_pkt(3, 4, 1'b1, d); push_pkt(0, 1, 1'b1, d); end
      if (c == 2) hold[3] = 1'b1;
      if (c == 4) hold[3] = 1'b0;
      @(negedge clk_i);
      if (c == 2 || c == 3) begin
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL bubble_gap: cycle %0d got valid_o=%b required 0", c, valid_o); end
      end
      if (c < 6) begin
        total++; if (ready_o[0] !== 1'b0) begin bad++; $display("FAIL bubble_block: cycle %0d got ready_o[0]=%b required 0", c, ready_o[0]); end
      end else begin
        total++; if (!(valid_o && gnt_idx_o === 3'd0)) begin bad++; $display("FAIL bubble_next: got valid=%b idx=%0d required valid=1 idx=0", valid_o, gnt_idx_o); end
      end
    end
    drain("bubble");
  endtask

  task automatic test_timeout();
    logic [FW-1:0] d;
    push_pkt(1, 6, 1'b0, d);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      total++;
      if (timeout_o !== (c >= 4)) begin
        bad++; $display("FAIL wd_timeout: after %0d handshakes got %b required %b", c, timeout_o, c >= 4);
      end
    end
    @(negedge clk_i);
    total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL wd_sticky: got %b required 1", timeout_o); end
    total++; if (locked_o !== 1'b1) begin bad++; $display("FAIL wd_locked: got %b required 1", locked_o); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wd_flits: got %0d pending required 0", exp_q.size()); end
    @(posedge clk_i); #1 rst_ni = 1'b0;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    @(negedge clk_i);
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL wd_rst_timeout: got %b required 0", timeout_o); end
    total++; if (locked_o !== 1'b0) begin bad++; $display("FAIL wd_rst_locked: got %b required 0", locked_o); end
    // With rr_ptr back at 0, input 0 must beat input 4.
    @(posedge clk_i); #1;
    push_pkt(0, 1, 1'b1, d);
    push_pkt(4, 1, 1'b1, d);
    @(negedge clk_i);
    total++; if (!(valid_o && gnt_idx_o === 3'd0)) begin bad++; $display("FAIL wd_rst_ptr: got valid=%b idx=%0d required idx=0", valid_o, gnt_idx_o); end
    drain("timeout");
  endtask

  initial begin
    test_reset();
    test_rr_single();
    test_lock();
    test_stall();
    test_bubble();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

endmodule
